// File: rtl/rs_arb_pkg.sv
// Types and defaults shared by the RS frame arbiter and its round-robin core.
package rs_arb_pkg;
    import rs_encoder_pkg::RS_K;

    localparam int NUM_SRC_DEFAULT     = 4;
    localparam int FRAME_BYTES_DEFAULT = RS_K;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2,
        DROP = 2'd3
    } arb_state_e;

    // Width of a source index (SRC_W); kept at least one bit wide.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rs_encoder_pkg.sv
// Shared Reed-Solomon code geometry; RS(255,223) frames carry RS_K data bytes.
package rs_encoder_pkg;
    localparam int RS_K = 223;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_oh_o,
    output logic [W-1:0] grant_idx_o,
    output logic         grant_vld_o
);
    logic [W-1:0] rot_idx [N];
    logic [N-1:0] rot_req;

    // Rotate the request vector so position 0 is the current priority holder.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot_idx[gi] = W'((int'(ptr_i) + gi) % N);
            assign rot_req[gi] = req_i[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_vld_o = |rot_req;
        grant_idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                grant_idx_o = rot_idx[k];
            end
        end
        grant_oh_o = '0;
        if (grant_vld_o) begin
            grant_oh_o[grant_idx_o] = 1'b1;
        end
    end
endmodule

// File: rtl/rs_frame_arbiter.sv
// Round-robin merge of NUM_SRC byte streams into fixed FRAME_BYTES RS frames (pad short, drop long).
// Optional RS_ARB_STATS_EN adds saturating frame/pad/drop counters.
module rs_frame_arbiter
    import rs_arb_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEFAULT,
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_SRC-1:0]         s_axis_valid,
    output logic [NUM_SRC-1:0]         s_axis_ready,
    input  logic [NUM_SRC-1:0]         s_axis_last,
    input  logic [NUM_SRC*8-1:0]       s_axis_data,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic [7:0]                 m_axis_data,
    output logic                       m_axis_last,
    output logic [src_w(NUM_SRC)-1:0]  m_axis_src,
    output logic                       err_short,
    output logic                       err_overlong
`ifdef RS_ARB_STATS_EN
    ,
    output logic [31:0]                stat_frames,
    output logic [31:0]                stat_pad_bytes,
    output logic [31:0]                stat_drop_bytes
`endif
);
    localparam int SRC_W = src_w(NUM_SRC);
    localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

    arb_state_e         state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [NUM_SRC-1:0] grant_oh_q, grant_oh_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_short_q, err_short_d;
    logic               err_overlong_q, err_overlong_d;

    logic [NUM_SRC-1:0] arb_oh;
    logic [SRC_W-1:0]   arb_idx;
    logic               arb_vld;

    logic [7:0]         src_byte [NUM_SRC];
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               m_hs;
    logic               drop_hs;
    logic               at_last;
    logic [SRC_W-1:0]   next_ptr;

    rr_arbiter #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_rr (
        .req_i       (s_axis_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (arb_oh),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_byte
            assign src_byte[gi] = s_axis_data[gi*8 +: 8];
        end
    endgenerate

    assign sel_valid = s_axis_valid[grant_q];
    assign sel_last  = s_axis_last[grant_q];
    assign sel_data  = src_byte[grant_q];
    assign at_last   = (cnt_q == LAST_CNT);
    assign next_ptr  = (grant_q == LAST_SRC) ? '0 : grant_q + SRC_W'(1);

    // Stream path is purely combinational so the granted source sees no extra latency.
    always_comb begin
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        s_axis_ready = '0;
        case (state_q)
            PASS: begin
                m_axis_valid = sel_valid;
                m_axis_data  = sel_data;
                if (m_axis_ready) begin
                    s_axis_ready = grant_oh_q;
                end
            end
            PAD: begin
                m_axis_valid = 1'b1;
            end
            DROP: begin
                s_axis_ready = grant_oh_q;
            end
            default: ;
        endcase
    end

    assign m_hs         = m_axis_valid && m_axis_ready;
    assign drop_hs      = (state_q == DROP) && sel_valid;
    assign m_axis_last  = ((state_q == PASS) || (state_q == PAD)) && at_last;
    assign m_axis_src   = grant_q;
    assign err_short    = err_short_q;
    assign err_overlong = err_overlong_q;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        grant_oh_d     = grant_oh_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        err_short_d    = 1'b0;
        err_overlong_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && arb_vld) begin
                    state_d    = PASS;
                    grant_d    = arb_idx;
                    grant_oh_d = arb_oh;
                    cnt_d      = '0;
                end
            end
            PASS: begin
                if (m_hs) begin
                    if (at_last) begin
                        cnt_d = '0;
                        if (sel_last) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_ptr;
                        end else begin
                            state_d        = DROP;
                            err_overlong_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (sel_last) begin
                            state_d     = PAD;
                            err_short_d = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                if (m_hs) begin
                    if (at_last) begin
                        cnt_d    = '0;
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DROP: begin
                // Surplus bytes are swallowed until the source closes its frame.
                if (drop_hs && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_oh_q     <= '0;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            err_short_q    <= 1'b0;
            err_overlong_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            grant_oh_q     <= grant_oh_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            err_short_q    <= err_short_d;
            err_overlong_q <= err_overlong_d;
        end
    end

`ifdef RS_ARB_STATS_EN
    logic [31:0] stat_frames_q;
    logic [31:0] stat_pad_bytes_q;
    logic [31:0] stat_drop_bytes_q;
    logic        frame_done;

    assign frame_done = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames_q     <= '0;
            stat_pad_bytes_q  <= '0;
            stat_drop_bytes_q <= '0;
        end else begin
            if (frame_done && (stat_frames_q != '1)) begin
                stat_frames_q <= stat_frames_q + 32'd1;
            end
            if ((state_q == PAD) && m_hs && (stat_pad_bytes_q != '1)) begin
                stat_pad_bytes_q <= stat_pad_bytes_q + 32'd1;
            end
            if (drop_hs && (stat_drop_bytes_q != '1)) begin
                stat_drop_bytes_q <= stat_drop_bytes_q + 32'd1;
            end
        end
    end

    assign stat_frames     = stat_frames_q;
    assign stat_pad_bytes  = stat_pad_bytes_q;
    assign stat_drop_bytes = stat_drop_bytes_q;
`endif
endmodule
